// File: rtl/core_defines.sv
// Shared core widths, register-select types and arbiter defaults.
// Imported by the writeback port arbiter slice.
package core_defines;

  localparam int XLEN      = 32;
  localparam int REG_SEL_W = 5;

  typedef logic [REG_SEL_W-1:0] reg_sel_t;
  typedef logic [XLEN-1:0]      xlen_t;

  localparam reg_sel_t REG_X0 = '0;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_MAX_WAIT = 8;

  typedef struct packed {
    logic     we;
    reg_sel_t sel;
    xlen_t    data;
  } rf_wr_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Regfile write-port arbitration bundle: writeback, multi-cycle
// result handshake, regfile port and decode scoreboard queries.
interface wb_port_arbiter_if;
  import core_defines::*;

  logic     wb_en;
  reg_sel_t wb_sel;
  xlen_t    wb_data;
  logic     mc_valid;
  reg_sel_t mc_sel;
  xlen_t    mc_data;
  logic     mc_ready;
  logic     w_regfile;
  reg_sel_t sel_regfile;
  xlen_t    data_regfile;
  reg_sel_t rs1_q;
  reg_sel_t rs2_q;
  logic     rs1_busy;
  logic     rs2_busy;
  logic     drain_req;

  modport slave (
    input  wb_en, wb_sel, wb_data,
    input  mc_valid, mc_sel, mc_data,
    input  rs1_q, rs2_q,
    output mc_ready,
    output w_regfile, sel_regfile, data_regfile,
    output rs1_busy, rs2_busy, drain_req
  );

  modport master (
    output wb_en, wb_sel, wb_data,
    output mc_valid, mc_sel, mc_data,
    output rs1_q, rs2_q,
    input  mc_ready,
    input  w_regfile, sel_regfile, data_regfile,
    input  rs1_busy, rs2_busy, drain_req
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// Ordered multi-cycle result buffer with per-entry kill bits,
// CAM-style WAW kill against writeback and busy lookup for decode.
module wb_arb_fifo
  import core_defines::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  reg_sel_t push_sel,
  input  xlen_t    push_data,
  input  logic     pop,
  input  logic     kill_en,
  input  reg_sel_t kill_sel,
  input  reg_sel_t rs1_q,
  input  reg_sel_t rs2_q,
  output logic     empty,
  output logic     full,
  output logic     head_killed,
  output reg_sel_t head_sel,
  output xlen_t    head_data,
  output logic     rs1_busy,
  output logic     rs2_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  reg_sel_t         sel_q  [DEPTH];
  xlen_t            data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] kl;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    count;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign head_killed = kl[rp];
  assign head_sel    = sel_q[rp];
  assign head_data   = data_q[rp];

  // Push is applied last so a full-buffer push+pop reuses the freed slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld   <= '0;
      kl    <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && vld[i] && sel_q[i] == kill_sel)
          kl[i] <= 1'b1;
      end
      if (pop) begin
        vld[rp] <= 1'b0;
        kl[rp]  <= 1'b0;
        rp      <= rp + PW'(1);
      end
      if (push) begin
        vld[wp]    <= 1'b1;
        kl[wp]     <= kill_en && (push_sel == kill_sel);
        sel_q[wp]  <= push_sel;
        data_q[wp] <= push_data;
        wp         <= wp + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && !kl[i]) begin
        if (rs1_q != REG_X0 && sel_q[i] == rs1_q)
          rs1_busy = 1'b1;
        if (rs2_q != REG_X0 && sel_q[i] == rs2_q)
          rs2_busy = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: writeback first, buffered results drain idle cycles.
// Optional macro WB_ARB_BYPASS_EN lets results skip an empty buffer.
module wb_port_arbiter
  import core_defines::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clock,
  input  logic                reset,
  wb_port_arbiter_if.slave    bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic          wb_wr;
  logic          mc_x0;
  logic          empty;
  logic          full;
  logic          head_killed;
  reg_sel_t      head_sel;
  xlen_t         head_data;
  logic          pop;
  logic          push;
  logic          byp;
  logic          ready_raw;
  logic          mc_ready;
  logic [WW-1:0] wait_cnt;
  rf_wr_t        port;

  assign wb_wr = bus.wb_en && (bus.wb_sel != REG_X0);
  assign mc_x0 = (bus.mc_sel == REG_X0);
  assign pop   = !empty && (head_killed || !wb_wr);

`ifdef WB_ARB_BYPASS_EN
  assign byp       = bus.mc_valid && empty && !wb_wr && !mc_x0;
  assign ready_raw = !full || pop;
`else
  assign byp       = 1'b0;
  assign ready_raw = !full;
`endif

  assign mc_ready = reset && ready_raw;
  assign push     = bus.mc_valid && mc_ready && !mc_x0 && !byp;

  wb_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .push_sel    (bus.mc_sel),
    .push_data   (bus.mc_data),
    .pop         (pop),
    .kill_en     (wb_wr),
    .kill_sel    (bus.wb_sel),
    .rs1_q       (bus.rs1_q),
    .rs2_q       (bus.rs2_q),
    .empty       (empty),
    .full        (full),
    .head_killed (head_killed),
    .head_sel    (head_sel),
    .head_data   (head_data),
    .rs1_busy    (bus.rs1_busy),
    .rs2_busy    (bus.rs2_busy)
  );

  always_comb begin
    port = '0;
    if (!reset) begin
      port = '0;
    end else if (wb_wr) begin
      port = '{we: 1'b1, sel: bus.wb_sel, data: bus.wb_data};
    end else if (!empty && !head_killed) begin
      port = '{we: 1'b1, sel: head_sel, data: head_data};
    end else if (byp) begin
      port = '{we: 1'b1, sel: bus.mc_sel, data: bus.mc_data};
    end
  end

  // Saturates at MAX_WAIT so drain_req holds until the bubble pops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (empty || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign bus.mc_ready     = mc_ready;
  assign bus.w_regfile    = port.we;
  assign bus.sel_regfile  = port.sel;
  assign bus.data_regfile = port.data;
  assign bus.drain_req    = reset && (wait_cnt >= WAIT_MAX);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default build, bypass disabled).
// Inputs change 1ns after posedge; outputs checked before the next edge.
module tb_wb_port_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] rf [32];

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .DEPTH    (4),
    .MAX_WAIT (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (bus.w_regfile)
      rf[bus.sel_regfile] <= bus.data_regfile;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] sel,
                    input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_sel  = sel;
    bus.wb_data = data;
  endtask

  task automatic mc(input logic v, input logic [4:0] sel,
                    input logic [31:0] data);
    bus.mc_valid = v;
    bus.mc_sel   = sel;
    bus.mc_data  = data;
  endtask

  task automatic port(input string tag, input logic we,
                      input logic [4:0] sel, input logic [31:0] data);
    chk({tag, "_we"}, 32'(bus.w_regfile), 32'(we));
    chk({tag, "_sel"}, 32'(bus.sel_regfile), 32'(sel));
    chk({tag, "_data"}, bus.data_regfile, data);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b0;
    wb(1'b1, 5'd3, 32'h33);
    mc(1'b0, 5'd0, 32'h0);
    bus.rs1_q = 5'd0;
    bus.rs2_q = 5'd0;
    #2;
    chk("rst_ready", 32'(bus.mc_ready), 32'd0);
    port("rst_port", 1'b0, 5'd0, 32'h0);
    chk("rst_drain", 32'(bus.drain_req), 32'd0);
    chk("rst_busy", 32'(bus.rs1_busy), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("post_rst_ready", 32'(bus.mc_ready), 32'd1);
    tick();

    // single buffered result x5
    mc(1'b1, 5'd5, 32'hDEAD);
    bus.rs1_q = 5'd5;
    #1;
    chk("t1_ready", 32'(bus.mc_ready), 32'd1);
    chk("t1_nobyp", 32'(bus.w_regfile), 32'd0);
    chk("t1_busy0", 32'(bus.rs1_busy), 32'd0);
    tick();
    mc(1'b0, 5'd0, 32'h0);
    #1;
    port("t1_drain", 1'b1, 5'd5, 32'hDEAD);
    chk("t1_busy1", 32'(bus.rs1_busy), 32'd1);
    tick();
    port("t1_idle", 1'b0, 5'd0, 32'h0);
    chk("t1_busy2", 32'(bus.rs1_busy), 32'd0);
    chk("t1_rf5", rf[5], 32'hDEAD);

    // fill under writeback pressure
    bus.rs1_q = 5'd0;
    wb(1'b1, 5'd3, 32'h300); mc(1'b1, 5'd10, 32'hA0);
    #1; port("t2_wb3", 1'b1, 5'd3, 32'h300);
    tick();
    wb(1'b1, 5'd4, 32'h400); mc(1'b1, 5'd11, 32'hA1);
    tick();
    wb(1'b1, 5'd6, 32'h600); mc(1'b1, 5'd12, 32'hA2);
    tick();
    wb(1'b1, 5'd7, 32'h700); mc(1'b1, 5'd13, 32'hA3);
    #1; chk("t2_ready4", 32'(bus.mc_ready), 32'd1);
    tick();
    wb(1'b1, 5'd8, 32'h800); mc(1'b1, 5'd14, 32'hA4);
    #1;
    chk("t2_full", 32'(bus.mc_ready), 32'd0);
    port("t2_wb8", 1'b1, 5'd8, 32'h800);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_full_pop", 32'(bus.mc_ready), 32'd0);
    port("t2_h10", 1'b1, 5'd10, 32'hA0);
    tick();
    chk("t2_ready5", 32'(bus.mc_ready), 32'd1);
    port("t2_h11", 1'b1, 5'd11, 32'hA1);
    tick();
    mc(1'b0, 5'd0, 32'h0);
    bus.rs2_q = 5'd14;
    #1;
    port("t2_h12", 1'b1, 5'd12, 32'hA2);
    chk("t2_busy14", 32'(bus.rs2_busy), 32'd1);
    tick();
    port("t2_h13", 1'b1, 5'd13, 32'hA3);
    tick();
    port("t2_h14", 1'b1, 5'd14, 32'hA4);
    tick();
    port("t2_idle", 1'b0, 5'd0, 32'h0);
    chk("t2_busy14_0", 32'(bus.rs2_busy), 32'd0);
    bus.rs2_q = 5'd0;

    // WAW kill on x9
    wb(1'b1, 5'd3, 32'h333); mc(1'b1, 5'd9, 32'h1111);
    tick();
    wb(1'b1, 5'd9, 32'h2222); mc(1'b0, 5'd0, 32'h0);
    bus.rs1_q = 5'd9;
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_busy", 32'(bus.rs1_busy), 32'd0);
    port("t3_kpop", 1'b0, 5'd0, 32'h0);
    tick();
    port("t3_idle", 1'b0, 5'd0, 32'h0);
    chk("t3_rf9", rf[9], 32'h2222);
    bus.rs1_q = 5'd0;

    // starvation and forced bubble
    wb(1'b1, 5'd3, 32'h3); mc(1'b1, 5'd20, 32'h5555);
    tick();
    mc(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t4_wait%0d", k), 32'(bus.drain_req), 32'd0);
      tick();
    end
    chk("t4_req", 32'(bus.drain_req), 32'd1);
    port("t4_wb", 1'b1, 5'd3, 32'h3);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_req_hold", 32'(bus.drain_req), 32'd1);
    port("t4_bubble", 1'b1, 5'd20, 32'h5555);
    tick();
    chk("t4_req_drop", 32'(bus.drain_req), 32'd0);
    port("t4_idle", 1'b0, 5'd0, 32'h0);

    // x0 result is swallowed
    mc(1'b1, 5'd0, 32'hFFFF);
    #1;
    chk("t5_ready", 32'(bus.mc_ready), 32'd1);
    port("t5_port0", 1'b0, 5'd0, 32'h0);
    tick();
    mc(1'b0, 5'd0, 32'h0);
    #1;
    port("t5_port1", 1'b0, 5'd0, 32'h0);
    tick();
    chk("t5_wait", 32'(bus.drain_req), 32'd0);

    // reset mid-drain
    wb(1'b1, 5'd3, 32'h3); mc(1'b1, 5'd21, 32'hC1);
    tick();
    mc(1'b1, 5'd22, 32'hC2);
    tick();
    mc(1'b1, 5'd23, 32'hC3);
    tick();
    wb(1'b0, 5'd0, 32'h0); mc(1'b0, 5'd0, 32'h0);
    bus.rs1_q = 5'd22;
    #1;
    port("t6_h21", 1'b1, 5'd21, 32'hC1);
    chk("t6_busy", 32'(bus.rs1_busy), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    port("t6_rst", 1'b0, 5'd0, 32'h0);
    chk("t6_rst_ready", 32'(bus.mc_ready), 32'd0);
    chk("t6_rst_busy", 32'(bus.rs1_busy), 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_ready", 32'(bus.mc_ready), 32'd1);
    chk("t6_busy_post", 32'(bus.rs1_busy), 32'd0);
    port("t6_post", 1'b0, 5'd0, 32'h0);
    tick();
    port("t6_empty", 1'b0, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order writeback stage and a multi-cycle result source such as a divider or a long-latency load return. Writeback always wins the port. Multi-cycle results wait in a small ordered buffer and drain into idle port cycles. The block also gives decode a per-register pending-write scoreboard. If the buffer starves, it requests one bubble cycle from decode so the buffer can drain.

## Interface
Parameters:
- DEPTH, 4: result-buffer entries; a power of two, at least 2.
- MAX_WAIT, 8: consecutive non-empty cycles without a drain before a bubble is requested.

Ports:
- clock  in  1  the single clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_en  in  1  writeback write request; always accepted, no backpressure.
- wb_sel  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- mc_valid  in  1  multi-cycle result valid.
- mc_sel  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle result data.
- mc_ready  out  1  high when a result is accepted this cycle; equals not-full.
- w_regfile  out  1  regfile write enable.
- sel_regfile  out  5  regfile write select.
- data_regfile  out  32  regfile write data.
- rs1_q, rs2_q  in  5 each  decode source-register queries.
- rs1_busy, rs2_busy  out  1 each  a valid buffered write to that register is pending.
- drain_req  out  1  asks decode to insert one bubble so writeback is idle next cycle.

## Operation
- Handshake: a multi-cycle result transfers when mc_valid and mc_ready are both high on a clock edge.
- x0 results are consumed and discarded: they are never buffered and never written.
- Port mux, priority order:
  1. wb_en with wb_sel != 0 drives the port from the writeback inputs.
  2. Otherwise a valid buffer head drives the port and is popped.
  3. Otherwise the port is idle: w_regfile=0, sel_regfile=0, data_regfile=0.
- Killed heads: a killed entry at the head pops with w_regfile=0 and does not consume a port cycle's write.
- WAW kill: when writeback writes register r, every valid buffered entry with sel==r is marked killed that cycle. A newer writeback result is never overwritten by an older buffered one.
- Busy outputs:
  - rs*_busy = OR over buffered entries that are valid, not killed, and have sel==rs*_q, for rs*_q != 0.
  - The entry draining this cycle still counts as busy, because the regfile has no write-through forwarding.
- Starvation:
  - wait_cnt increments each cycle the buffer is non-empty and no pop occurs.
  - wait_cnt clears on any pop or when the buffer is empty.
  - drain_req=1 when wait_cnt >= MAX_WAIT, held until the next pop.
  - Decode guarantees wb_en=0 the cycle after it sees drain_req.
- Full buffer: mc_ready=0; push and pop in the same cycle are allowed.
  - When full, a pop frees the slot combinationally only when WB_ARB_BYPASS_EN is set.
  - Without the macro, mc_ready depends on registered count only.

## Timing
- Reset (reset=0, asynchronous): buffer empty, pointers=0, wait_cnt=0, all killed bits 0.
- Output values during reset: mc_ready=0, w_regfile=0, sel_regfile=0, data_regfile=0, rs*_busy=0, drain_req=0.
- Writeback path: combinational, zero added latency.
- Buffered path: result accepted at edge N reaches the port no earlier than cycle N+1.
- mc_ready asserts in the first cycle after reset deasserts.
- Reset mid-operation: all buffered results are lost. The multi-cycle source is reset by the same signal.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - When the buffer is empty and writeback is idle, a handshaking multi-cycle result goes straight to the port in the same cycle without being buffered.
  - mc_ready = not full, or a pop occurs this cycle.
- WB_ARB_BYPASS_EN undefined:
  - Every result is buffered, so minimum latency to the port is 1 cycle.
  - mc_ready = not full, from registered state only.

## Structure
- Shared package core_defines holds: XLEN=32, REG_SEL_W=5, the x0 index constant, and the default DEPTH/MAX_WAIT.
- Sub-module wb_arb_fifo holds storage, pointers, count, killed bits, the CAM-style sel compare for kill, and busy lookup.
- The top level holds the port mux, handshake, starvation counter, and bypass logic.

## Test plan
- Reset, then mc result x5=0xDEAD with writeback idle, macro undefined:
  - The port writes x5=0xDEAD one cycle after the handshake.
  - rs1_q=5 gives busy=1 in the accept-to-write window.
- Writeback active on x3,x4,x6,x7 while four mc results arrive: all four are buffered, then mc_ready=0. The fifth stalls until the first idle writeback cycle pops the head.
- Buffered x9=0x1111, then writeback x9=0x2222: the entry is killed, busy(x9)=0, and the drain produces no write. x9 ends as 0x2222.
- Writeback busy for MAX_WAIT=8 cycles with one entry buffered: drain_req rises at cycle 8. The forced bubble pops the entry, and drain_req drops the next cycle.
- mc result to x0: consumed with mc_ready=1. There is no port write and the buffer count stays 0.
- Assert reset mid-drain with 3 entries: outputs go 0 immediately, and after release the buffer is empty and mc_ready=1.
